// File: rtl/phi_landscape_pkg.sv
// ---------------------------------------------------------------------------
// phi_landscape_pkg
// Shared definitions for the phi-landscape pipeline stages.
//   - Q14 fixed-point constants (FRAC, ONE_Q14)
//   - Default word width and oscillator count
//   - lane_lsb(): low bit of a lane within a packed lane bus
//   - drift_state_e: scan FSM states used by drift_integrator
// No ports (package).
// ---------------------------------------------------------------------------
package phi_landscape_pkg;

  localparam int FRAC                = 14;
  localparam int ONE_Q14             = 1 << FRAC;
  localparam int DEF_WIDTH           = 18;
  localparam int DEF_NUM_OSCILLATORS = 21;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } drift_state_e;

  // Lane g of a packed bus occupies [g*width +: width].
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/drift_sat_alu.sv
// ---------------------------------------------------------------------------
// drift_sat_alu
// Combinational per-lane drift update, shared by all lanes of the integrator:
//   sum = d + (f >>> GAIN_SHIFT) - leak,  leak = d >>> LEAK_SHIFT
//   (leak forced to 0 when the lane's 2:1 harmonic flag is set),
//   result saturated to [-DRIFT_MAX, +DRIFT_MAX].
// Optional macro DRIFT_DEADBAND_EN: forces with |f| < DEADBAND contribute no
// increment (leak still applies).
// Ports:
//   d_i          signed committed drift of the lane
//   f_i          signed snapshot force of the lane
//   near_harm_i  lane's snapshot near-harmonic flag
//   sum_o        saturated new drift value
// ---------------------------------------------------------------------------
module drift_sat_alu #(
  parameter int WIDTH      = 18,
  parameter int GAIN_SHIFT = 4,
  parameter int LEAK_SHIFT = 8,
  parameter int DRIFT_MAX  = 8192,
  parameter int DEADBAND   = 64
) (
  input  logic signed [WIDTH-1:0] d_i,
  input  logic signed [WIDTH-1:0] f_i,
  input  logic                    near_harm_i,
  output logic signed [WIDTH-1:0] sum_o
);

  // Two guard bits: d + f/16 can exceed the word range before saturation.
  localparam int EW = WIDTH + 2;

`ifdef DRIFT_DEADBAND_EN
  localparam logic DB_EN = 1'b1;
`else
  localparam logic DB_EN = 1'b0;
`endif

  localparam logic signed [EW-1:0] MAX_E = EW'(DRIFT_MAX);
  localparam logic signed [EW-1:0] MIN_E = EW'(-DRIFT_MAX);
  localparam logic [WIDTH:0]       DB_TH = (WIDTH+1)'(DEADBAND);

  logic signed [EW-1:0] d_ext_s;
  logic signed [EW-1:0] f_ext_s;
  logic signed [EW-1:0] f_term_s;
  logic signed [EW-1:0] leak_s;
  logic signed [EW-1:0] sum_s;
  logic        [WIDTH:0] f_mag_s;
  logic                  f_small_s;

  always_comb begin
    d_ext_s = EW'(d_i);
    f_ext_s = EW'(f_i);

    // Magnitude needs one extra bit so the most negative force is exact.
    if (f_i[WIDTH-1]) begin
      f_mag_s = (WIDTH+1)'(-f_ext_s);
    end else begin
      f_mag_s = (WIDTH+1)'(f_ext_s);
    end
    f_small_s = DB_EN && (f_mag_s < DB_TH);

    if (f_small_s) begin
      f_term_s = '0;
    end else begin
      f_term_s = f_ext_s >>> GAIN_SHIFT;
    end

    // Near a 2:1 catastrophe the accumulated push must not bleed away.
    if (near_harm_i) begin
      leak_s = '0;
    end else begin
      leak_s = d_ext_s >>> LEAK_SHIFT;
    end

    sum_s = d_ext_s + f_term_s - leak_s;

    if (sum_s > MAX_E) begin
      sum_o = WIDTH'(MAX_E);
    end else if (sum_s < MIN_E) begin
      sum_o = WIDTH'(MIN_E);
    end else begin
      sum_o = sum_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/drift_integrator.sv
// ---------------------------------------------------------------------------
// drift_integrator
// Integrates each oscillator's restoring force into a frequency drift term.
// On an accepted update strobe the force and harmonic-flag vectors are
// snapshotted, one lane per cycle is run through a single shared saturating
// ALU into a shadow array, and the whole shadow is then committed to
// drift_packed in one cycle so downstream never sees a mixed vector.
// Optional macro DRIFT_DEADBAND_EN enables the force deadband in the ALU.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clk_en              update strobe, accepted only in IDLE
//   force_packed        signed forces, lane g at [g*WIDTH +: WIDTH]
//   near_harmonic_2_1   per-lane 2:1 catastrophe flags
//   drift_packed        committed signed drift, same packing
//   busy                high from the cycle after acceptance through COMMIT
//   update_done         one-cycle pulse coincident with the new drift_packed
//   overrun_count       saturating count of strobes dropped while busy
// ---------------------------------------------------------------------------
module drift_integrator
  import phi_landscape_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int FRAC            = phi_landscape_pkg::FRAC,
  parameter int NUM_OSCILLATORS = DEF_NUM_OSCILLATORS,
  parameter int GAIN_SHIFT      = 4,
  parameter int LEAK_SHIFT      = 8,
  parameter int DRIFT_MAX       = 8192,
  parameter int DEADBAND        = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clk_en,
  input  logic [NUM_OSCILLATORS*WIDTH-1:0] force_packed,
  input  logic [NUM_OSCILLATORS-1:0]       near_harmonic_2_1,
  output logic [NUM_OSCILLATORS*WIDTH-1:0] drift_packed,
  output logic                             busy,
  output logic                             update_done,
  output logic [7:0]                       overrun_count
);

  localparam int VW    = NUM_OSCILLATORS * WIDTH;
  localparam int IDX_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OSCILLATORS - 1);

  // Elaboration sanity checks on the Q-format and saturation bound.
  if (FRAC >= WIDTH) begin : g_frac_chk
    $error("drift_integrator: FRAC must be smaller than WIDTH");
  end
  if (DRIFT_MAX >= (1 << (WIDTH - 1))) begin : g_max_chk
    $error("drift_integrator: DRIFT_MAX must fit in a signed WIDTH word");
  end

  drift_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [VW-1:0]              force_snap_q;
  logic [NUM_OSCILLATORS-1:0] harm_snap_q;
  logic signed [WIDTH-1:0]    shadow_q [NUM_OSCILLATORS];
  logic [VW-1:0]              drift_q;
  logic                       busy_q;
  logic                       done_q;
  logic [7:0]                 ovr_q;

  logic snap_en_s;
  logic lane_we_s;
  logic commit_s;
  logic drop_s;

  logic signed [WIDTH-1:0] d_lane_s;
  logic signed [WIDTH-1:0] f_lane_s;
  logic                    h_lane_s;
  logic signed [WIDTH-1:0] sum_lane_s;

  // Next-state and control decode for the scan FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_en_s = 1'b0;
    lane_we_s = 1'b0;
    commit_s  = 1'b0;
    drop_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clk_en) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          snap_en_s = 1'b1;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SCAN: begin
        lane_we_s = 1'b1;
        drop_s    = clk_en;
        // idx holds at the last lane; it only returns to 0 through COMMIT.
        if (idx_q == LAST_IDX) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        commit_s = 1'b1;
        drop_s   = clk_en;
        state_d  = ST_IDLE;
        idx_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Select the current lane's committed drift, snapshot force and flag.
  always_comb begin
    d_lane_s = drift_q[lane_lsb(int'(idx_q), WIDTH) +: WIDTH];
    f_lane_s = force_snap_q[lane_lsb(int'(idx_q), WIDTH) +: WIDTH];
    h_lane_s = harm_snap_q[idx_q];
  end

  drift_sat_alu #(
    .WIDTH      (WIDTH),
    .GAIN_SHIFT (GAIN_SHIFT),
    .LEAK_SHIFT (LEAK_SHIFT),
    .DRIFT_MAX  (DRIFT_MAX),
    .DEADBAND   (DEADBAND)
  ) u_alu (
    .d_i         (d_lane_s),
    .f_i         (f_lane_s),
    .near_harm_i (h_lane_s),
    .sum_o       (sum_lane_s)
  );

  // FSM state and lane index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Input snapshot, taken only when a strobe is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      force_snap_q <= '0;
      harm_snap_q  <= '0;
    end else if (snap_en_s) begin
      force_snap_q <= force_packed;
      harm_snap_q  <= near_harmonic_2_1;
    end
  end

  // Shadow array filled one lane per SCAN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < NUM_OSCILLATORS; g++) begin
        shadow_q[g] <= '0;
      end
    end else if (lane_we_s) begin
      shadow_q[idx_q] <= sum_lane_s;
    end
  end

  // Atomic commit of the full shadow into the output vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      drift_q <= '0;
    end else if (commit_s) begin
      for (int g = 0; g < NUM_OSCILLATORS; g++) begin
        drift_q[g*WIDTH +: WIDTH] <= shadow_q[g];
      end
    end
  end

  // Registered status outputs and the saturating overrun counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 8'd0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      done_q <= commit_s;
      if (drop_s && (ovr_q != 8'hFF)) begin
        ovr_q <= ovr_q + 8'd1;
      end
    end
  end

  assign drift_packed  = drift_q;
  assign busy          = busy_q;
  assign update_done   = done_q;
  assign overrun_count = ovr_q;

endmodule
